// File: rtl/fp_maxscan_ctrl_if.sv
// Operand stream in, single reduction result out, for the fp32 max/min scan controller.
interface fp_maxscan_ctrl_if #(
  parameter int IDX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             mode_min;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [IDX_W-1:0] out_index;
  logic [IDX_W:0]   out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, mode_min, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, mode_min, out_ready,
    output in_ready, out_valid, out_data, out_index, out_count, out_ovf
  );
endinterface

// File: rtl/fp_maxscan_ctrl.sv
// Streaming fp32 max/min reduction with first-occurrence index; one compare per accepted beat.
// Result registered one cycle after the last beat; input stalls while a result waits in DONE.
module fp_maxscan_ctrl #(
  parameter int IDX_W = 8
) (
  input logic              clk,
  input logic              rst,
  fp_maxscan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      best;
  logic [31:0]      best_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W:0]   cnt;
  logic [IDX_W:0]   cnt_nxt;
  logic             ovf;
  logic             ovf_nxt;
  logic             mode;
  logic             mode_nxt;
  logic             accept;
  logic             finish;
  logic             better;

  // Sign-magnitude ordering: magnitude bits compare directly, reversed for negatives.
  function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
    if (a == b)
      return 1'b0;
    else if (a[31] != b[31])
      return ~a[31];
    else if (!a[31])
      return a[30:0] > b[30:0];
    else
      return a[30:0] < b[30:0];
  endfunction

  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign finish        = accept && bus.in_last;
  assign better        = mode ? gt(best, bus.in_data) : gt(bus.in_data, best);

  always_comb begin
    state_nxt = state;
    best_nxt  = best;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    mode_nxt  = mode;
    case (state)
      IDLE: begin
        if (accept) begin
          best_nxt  = bus.in_data;
          idx_nxt   = '0;
          cnt_nxt   = CNT_ONE;
          ovf_nxt   = 1'b0;
          mode_nxt  = bus.mode_min;
          state_nxt = bus.in_last ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (accept) begin
          // Beats past the representable length are consumed but never compared.
          if (cnt == CNT_MAX) begin
            ovf_nxt = 1'b1;
          end else begin
            if (better) begin
              best_nxt = bus.in_data;
              idx_nxt  = cnt[IDX_W-1:0];
            end
            cnt_nxt = cnt + CNT_ONE;
          end
          if (bus.in_last)
            state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      best  <= '0;
      idx   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      best  <= best_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
      mode  <= mode_nxt;
    end
  end

  // Result registers only move when a vector completes, so they hold through the next scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
    end else if (finish) begin
      bus.out_data  <= best_nxt;
      bus.out_index <= idx_nxt;
      bus.out_count <= cnt_nxt;
      bus.out_ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_fp_maxscan_ctrl.sv
// Directed bench: IDX_W=8 instance for functional cases, IDX_W=2 instance for overflow.
module tb_fp_maxscan_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [31:0] vq[$];
  logic [31:0] held;

  fp_maxscan_ctrl_if #(.IDX_W(8)) a ();
  fp_maxscan_ctrl_if #(.IDX_W(2)) b ();

  fp_maxscan_ctrl #(.IDX_W(8)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  fp_maxscan_ctrl #(.IDX_W(2)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at negedge; waits (bounded) for in_ready, presents one beat, returns at the next negedge.
  task automatic beat_a(input logic [31:0] d, input logic last, input logic m);
    int n;
    n = 0;
    while (!a.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 32'(a.in_ready), 32'd1);
    a.in_valid = 1'b1;
    a.in_data  = d;
    a.in_last  = last;
    a.mode_min = m;
    @(negedge clk);
    a.in_valid = 1'b0;
    a.in_last  = 1'b0;
  endtask

  task automatic beat_b(input logic [31:0] d, input logic last);
    b.in_valid = 1'b1;
    b.in_data  = d;
    b.in_last  = last;
    b.mode_min = 1'b0;
    @(negedge clk);
    b.in_valid = 1'b0;
    b.in_last  = 1'b0;
  endtask

  // First beat carries the requested mode; later beats carry the opposite, which must be ignored.
  task automatic run_vec(input logic m);
    for (int i = 0; i < vq.size(); i++)
      beat_a(vq[i], (i == vq.size() - 1), (i == 0) ? m : ~m);
  endtask

  task automatic check_res(input string tag, input logic [31:0] d, input logic [31:0] ix,
                           input logic [31:0] c, input logic [31:0] o);
    chk({tag, "_valid"}, 32'(a.out_valid), 32'd1);
    chk({tag, "_data"}, a.out_data, d);
    chk({tag, "_index"}, 32'(a.out_index), ix);
    chk({tag, "_count"}, 32'(a.out_count), c);
    chk({tag, "_ovf"}, 32'(a.out_ovf), o);
  endtask

  task automatic consume_a();
    a.out_ready = 1'b1;
    @(negedge clk);
    a.out_ready = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    a.in_valid = 1'b0; a.in_data = '0; a.in_last = 1'b0; a.mode_min = 1'b0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.in_last = 1'b0; b.mode_min = 1'b0; b.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_out_valid", 32'(a.out_valid), 32'd0);
    chk("rst_in_ready", 32'(a.in_ready), 32'd1);
    chk("rst_out_data", a.out_data, 32'h0);
    chk("rst_out_index", 32'(a.out_index), 32'd0);
    chk("rst_out_count", 32'(a.out_count), 32'd0);
    chk("rst_out_ovf", 32'(a.out_ovf), 32'd0);

    // Max: 1.0, 2.0, -3.0 -> 2.0 at index 1
    beat_a(32'h3F800000, 1'b0, 1'b0);
    beat_a(32'h40000000, 1'b0, 1'b1);
    chk("max_midscan_valid", 32'(a.out_valid), 32'd0);
    beat_a(32'hC0400000, 1'b1, 1'b1);
    check_res("max3", 32'h40000000, 32'd1, 32'd3, 32'd0);
    consume_a();
    chk("max3_after_hs_valid", 32'(a.out_valid), 32'd0);
    chk("max3_after_hs_ready", 32'(a.in_ready), 32'd1);

    // Min on the same vector -> -3.0 at index 2
    vq = '{32'h3F800000, 32'h40000000, 32'hC0400000};
    run_vec(1'b1);
    check_res("min3", 32'hC0400000, 32'd2, 32'd3, 32'd0);
    consume_a();

    // Max over negatives: -2.0 beats -3.0
    vq = '{32'hC0000000, 32'hC0400000};
    run_vec(1'b0);
    check_res("maxneg", 32'hC0000000, 32'd0, 32'd2, 32'd0);
    consume_a();

    // +0 beats -0; later +0 tie keeps index 1
    vq = '{32'h80000000, 32'h00000000, 32'h00000000};
    run_vec(1'b0);
    check_res("zeros", 32'h00000000, 32'd1, 32'd3, 32'd0);
    consume_a();

    // Min with a tie: 5.0, 5.0 -> index 0; then hold the result under backpressure
    vq = '{32'h40A00000, 32'h40A00000};
    run_vec(1'b1);
    check_res("bp", 32'h40A00000, 32'd0, 32'd2, 32'd0);
    a.in_valid = 1'b1;
    a.in_data  = 32'h7F000000;
    a.in_last  = 1'b1;
    a.mode_min = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(a.in_ready), 32'd0);
      chk("bp_out_valid", 32'(a.out_valid), 32'd1);
      chk("bp_out_data", a.out_data, 32'h40A00000);
      chk("bp_out_count", 32'(a.out_count), 32'd2);
    end
    a.in_valid = 1'b0;
    a.in_last  = 1'b0;
    consume_a();
    chk("bp_release_ready", 32'(a.in_ready), 32'd1);
    chk("bp_release_valid", 32'(a.out_valid), 32'd0);
    held = a.out_data;
    beat_a(32'h3F000000, 1'b0, 1'b0);
    chk("bp_hold_during_scan", a.out_data, 32'h40A00000);
    chk("bp_hold_index", 32'(a.out_index), 32'd0);
    beat_a(32'h3F800000, 1'b1, 1'b0);
    check_res("after_bp", 32'h3F800000, 32'd1, 32'd2, 32'd0);
    consume_a();

    // Reset in SCAN after two beats discards the vector
    beat_a(32'h42000000, 1'b0, 1'b0);
    beat_a(32'h42800000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(a.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(a.in_ready), 32'd1);
    chk("midrst_out_data", a.out_data, 32'h0);
    beat_a(32'h41200000, 1'b1, 1'b0);
    check_res("single", 32'h41200000, 32'd0, 32'd1, 32'd0);
    consume_a();

    // IDX_W=2: exactly four elements fills the counter without overflow
    beat_b(32'h3F800000, 1'b0);
    beat_b(32'h40000000, 1'b0);
    beat_b(32'h3F000000, 1'b0);
    beat_b(32'h40800000, 1'b1);
    chk("full4_valid", 32'(b.out_valid), 32'd1);
    chk("full4_data", b.out_data, 32'h40800000);
    chk("full4_index", 32'(b.out_index), 32'd3);
    chk("full4_count", 32'(b.out_count), 32'd4);
    chk("full4_ovf", 32'(b.out_ovf), 32'd0);
    b.out_ready = 1'b1;
    @(negedge clk);
    b.out_ready = 1'b0;

    // Six beats: fifth (8.0) and sixth are past capacity and ignored
    beat_b(32'h3F800000, 1'b0);
    beat_b(32'h3F800000, 1'b0);
    beat_b(32'h3F800000, 1'b0);
    beat_b(32'h3F800000, 1'b0);
    beat_b(32'h41000000, 1'b0);
    chk("ovf_midscan_valid", 32'(b.out_valid), 32'd0);
    beat_b(32'h3F000000, 1'b1);
    chk("ovf_valid", 32'(b.out_valid), 32'd1);
    chk("ovf_data", b.out_data, 32'h3F800000);
    chk("ovf_index", 32'(b.out_index), 32'd0);
    chk("ovf_count", 32'(b.out_count), 32'd4);
    chk("ovf_flag", 32'(b.out_ovf), 32'd1);
    b.out_ready = 1'b1;
    @(negedge clk);
    b.out_ready = 1'b0;
    chk("ovf_after_hs_ready", 32'(b.in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
